// File: rtl/sr_flag_arbiter_pkg.sv
// Shared encodings for the SR flag arbiter: FSM state codes and request op codes.
package sr_arb_pkg;
   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] APPLY = 2'd1;
   localparam logic [1:0] ACK   = 2'd2;

   localparam logic OP_SET = 1'b1;
   localparam logic OP_CLR = 1'b0;
endpackage

// File: rtl/sr_flag_bank.sv
// Bank of SR flags, each a D flop with D = s | (q & ~r).
module sr_flag_bank #(
   parameter int NFLAG = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [NFLAG-1:0] s,
   input  logic [NFLAG-1:0] r,
   output logic [NFLAG-1:0] q,
   output logic [NFLAG-1:0] qbar
);
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) q <= '0;
      else      q <= s | (q & ~r);
   end

   assign qbar = ~q;

   // The arbiter only ever drives one-hot s/r pulses for a single flag.
   a_no_sr_overlap: assert property (@(posedge clk) disable iff (!rst) (s & r) == '0);
endmodule

// File: rtl/sr_flag_arbiter.sv
// Round-robin arbiter serialising set/clear requests into a shared SR flag bank.
module sr_flag_arbiter
   import sr_arb_pkg::*;
#(
   parameter int NREQ  = 4,
   parameter int NFLAG = 8,
   parameter int FW    = (NFLAG > 1) ? $clog2(NFLAG) : 1
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [NREQ-1:0]    req,
   input  logic [NREQ-1:0]    req_op,
   input  logic [NREQ*FW-1:0] req_idx,
   output logic [NREQ-1:0]    gnt,
   output logic [NFLAG-1:0]   s_out,
   output logic [NFLAG-1:0]   r_out,
   output logic [NFLAG-1:0]   q,
   output logic [NFLAG-1:0]   qbar,
   output logic               busy,
   output logic               err
);
   localparam int PW = $clog2(NREQ);

   logic [1:0]       state;
   logic [PW-1:0]    rr_ptr, win, win_c;
   logic             found;
   logic [FW-1:0]    sel_idx;
   logic             sel_op, sel_ok, oor;
   logic [NFLAG-1:0] onehot;

   // First requester at or after rr_ptr, wrapping mod NREQ.
   always_comb begin
      found = 1'b0;
      win_c = '0;
      for (int i = 0; i < NREQ; i++) begin
         if (!found && req[(int'(rr_ptr) + i) % NREQ]) begin
            found = 1'b1;
            win_c = PW'((int'(rr_ptr) + i) % NREQ);
         end
      end
   end

   assign sel_idx = req_idx[win_c*FW +: FW];
   assign sel_op  = req_op[win_c];
   assign sel_ok  = int'(sel_idx) < NFLAG;
   assign onehot  = sel_ok ? (NFLAG'(1) << sel_idx) : '0;
   assign busy    = (state != IDLE);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state  <= IDLE;
         rr_ptr <= '0;
         win    <= '0;
         oor    <= 1'b0;
         s_out  <= '0;
         r_out  <= '0;
         gnt    <= '0;
         err    <= 1'b0;
      end else begin
         case (state)
            IDLE: if (found) begin
               win   <= win_c;
               oor   <= ~sel_ok;
               s_out <= (sel_op == OP_SET) ? onehot : '0;
               r_out <= (sel_op == OP_CLR) ? onehot : '0;
               state <= APPLY;
            end
            APPLY: begin
               s_out <= '0;
               r_out <= '0;
               gnt   <= NREQ'(1) << win;
               err   <= oor;
               state <= ACK;
            end
            ACK: begin
               gnt    <= '0;
               err    <= 1'b0;
               rr_ptr <= (win == PW'(NREQ-1)) ? '0 : win + 1'b1;
               state  <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   sr_flag_bank #(.NFLAG(NFLAG)) u_bank (
      .clk  (clk),
      .rst  (rst),
      .s    (s_out),
      .r    (r_out),
      .q    (q),
      .qbar (qbar)
   );
endmodule

// File: tb/tb_sr_flag_arbiter.sv
// Directed bench for sr_flag_arbiter: an 8-flag instance plus a 6-flag one for out-of-range indices.
module tb_sr_flag_arbiter;
   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic [3:0]  req = '0, req_op = '0, gnt;
   logic [11:0] req_idx = '0;
   logic [7:0]  s_out, r_out, q, qbar;
   logic        busy, err;

   logic [3:0]  b_req = '0, b_req_op = '0, b_gnt;
   logic [11:0] b_req_idx = '0;
   logic [5:0]  b_s_out, b_r_out, b_q, b_qbar;
   logic        b_busy, b_err;

   int total = 0;
   int bad = 0;

   always #5 clk = ~clk;

   sr_flag_arbiter #(.NREQ(4), .NFLAG(8)) dut (
      .clk(clk), .rst(rst), .req(req), .req_op(req_op), .req_idx(req_idx),
      .gnt(gnt), .s_out(s_out), .r_out(r_out), .q(q), .qbar(qbar), .busy(busy), .err(err)
   );

   sr_flag_arbiter #(.NREQ(4), .NFLAG(6)) dut6 (
      .clk(clk), .rst(rst), .req(b_req), .req_op(b_req_op), .req_idx(b_req_idx),
      .gnt(b_gnt), .s_out(b_s_out), .r_out(b_r_out), .q(b_q), .qbar(b_qbar), .busy(b_busy), .err(b_err)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic apply_reset();
      rst = 1'b0; req = '0; b_req = '0;
      tick(); tick();
      rst = 1'b1;
   endtask

   // Runs one full transaction for requester k on the 8-flag instance.
   task automatic run_one(input int k, input logic op, input logic [2:0] idx);
      req[k] = 1'b1; req_op[k] = op; req_idx[k*3 +: 3] = idx;
      tick(); tick();
      req[k] = 1'b0;
      tick();
   endtask

   task automatic test_reset();
      rst = 1'b0;
      for (int c = 0; c < 4; c++) begin
         req = 4'($urandom); req_op = 4'($urandom); req_idx = 12'($urandom);
         tick();
         total++; if (gnt !== 4'h0) begin bad++; $display("FAIL reset_gnt got=%h exp=0", gnt); end
         total++; if ({s_out, r_out} !== 16'h0) begin bad++; $display("FAIL reset_sr got=%h exp=0", {s_out, r_out}); end
         total++; if (q !== 8'h00 || qbar !== 8'hFF) begin bad++; $display("FAIL reset_q got q=%h qbar=%h exp 00/ff", q, qbar); end
         total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
      end
      req = 4'hF; req_op = 4'hF; req_idx = {3'd3, 3'd2, 3'd1, 3'd0};
      rst = 1'b1;
      tick(); tick();
      total++; if (gnt !== 4'b0001) begin bad++; $display("FAIL reset_first_gnt got=%b exp=0001", gnt); end
      req = '0;
      tick();
   endtask

   task automatic test_single_set();
      apply_reset();
      req = 4'b0001; req_op[0] = 1'b1; req_idx[2:0] = 3'd3;
      tick();
      total++; if (s_out !== 8'h08 || r_out !== 8'h00) begin bad++; $display("FAIL set_pulse got s=%h r=%h exp 08/00", s_out, r_out); end
      total++; if (busy !== 1'b1 || gnt !== 4'h0) begin bad++; $display("FAIL set_apply got busy=%b gnt=%b exp 1/0000", busy, gnt); end
      tick();
      total++; if (gnt !== 4'b0001) begin bad++; $display("FAIL set_gnt got=%b exp=0001", gnt); end
      total++; if (q !== 8'h08 || qbar !== 8'hF7) begin bad++; $display("FAIL set_q got q=%h qbar=%h exp 08/f7", q, qbar); end
      total++; if (s_out !== 8'h00 || busy !== 1'b1) begin bad++; $display("FAIL set_ack got s=%h busy=%b exp 00/1", s_out, busy); end
      req = '0;
      tick();
      total++; if (busy !== 1'b0 || gnt !== 4'h0) begin bad++; $display("FAIL set_idle got busy=%b gnt=%b exp 0/0000", busy, gnt); end
      total++; if (q !== 8'h08) begin bad++; $display("FAIL set_hold got=%h exp=08", q); end
   endtask

   task automatic test_contention();
      apply_reset();
      run_one(3, 1'b1, 3'd3);   // q=08 and rr_ptr wraps back to 0
      req_op[0] = 1'b1; req_idx[2:0] = 3'd1;
      req_op[2] = 1'b0; req_idx[8:6] = 3'd3;
      req = 4'b0101;
      tick(); tick();
      total++; if (gnt !== 4'b0001 || q !== 8'h0A) begin bad++; $display("FAIL cont_first got gnt=%b q=%h exp 0001/0a", gnt, q); end
      req[0] = 1'b0;
      tick(); tick();
      total++; if (r_out !== 8'h08) begin bad++; $display("FAIL cont_clr_pulse got=%h exp=08", r_out); end
      tick();
      total++; if (gnt !== 4'b0100 || q !== 8'h02) begin bad++; $display("FAIL cont_second got gnt=%b q=%h exp 0100/02", gnt, q); end
      req = '0;
      tick();
   endtask

   task automatic test_fairness();
      int n = 0;
      int last = -10;
      logic [3:0] e;
      apply_reset();
      req_op = 4'hF; req_idx = {3'd3, 3'd2, 3'd1, 3'd0};
      req = 4'hF;
      for (int c = 0; c < 15; c++) begin
         tick();
         if (gnt !== 4'h0) begin
            e = 4'b0001 << (n % 4);
            total++; if (gnt !== e) begin bad++; $display("FAIL rr_order n=%0d got=%b exp=%b", n, gnt, e); end
            if (n > 0) begin
               total++; if (c - last < 3) begin bad++; $display("FAIL rr_spacing got=%0d exp>=3", c - last); end
            end
            last = c;
            n++;
         end
      end
      total++; if (n != 5) begin bad++; $display("FAIL rr_count got=%0d exp=5", n); end
      total++; if (q !== 8'h0F) begin bad++; $display("FAIL rr_q got=%h exp=0f", q); end
      req = '0;
      tick(); tick(); tick();
   endtask

   task automatic test_out_of_range();
      apply_reset();
      b_req_op[1] = 1'b1;
      foreach (b_req_op[j]) b_req_op[j] = 1'b1;
      b_req_idx[5:3] = 3'd7;
      b_req = 4'b0010;
      tick();
      total++; if (b_s_out !== 6'h0 || b_r_out !== 6'h0) begin bad++; $display("FAIL oor_pulse got s=%h r=%h exp 0/0", b_s_out, b_r_out); end
      tick();
      total++; if (b_gnt !== 4'b0010 || b_err !== 1'b1) begin bad++; $display("FAIL oor_gnt_err got gnt=%b err=%b exp 0010/1", b_gnt, b_err); end
      total++; if (b_q !== 6'h0) begin bad++; $display("FAIL oor_q got=%h exp=00", b_q); end
      b_req = '0;
      tick();
      total++; if (b_err !== 1'b0 || b_gnt !== 4'h0) begin bad++; $display("FAIL oor_clear got err=%b gnt=%b exp 0/0000", b_err, b_gnt); end
      // idx == NFLAG is the first out-of-range value; NFLAG-1 is the last valid one
      b_req_idx[8:6] = 3'd6; b_req = 4'b0100;
      tick(); tick();
      total++; if (b_err !== 1'b1 || b_gnt !== 4'b0100) begin bad++; $display("FAIL oor_edge got err=%b gnt=%b exp 1/0100", b_err, b_gnt); end
      b_req = '0;
      tick();
      b_req_idx[11:9] = 3'd5; b_req = 4'b1000;
      tick(); tick();
      total++; if (b_err !== 1'b0 || b_q !== 6'h20) begin bad++; $display("FAIL oor_last_valid got err=%b q=%h exp 0/20", b_err, b_q); end
      b_req = '0;
      tick();
   endtask

   task automatic test_reset_mid_apply();
      apply_reset();
      req = 4'b0001; req_op[0] = 1'b1; req_idx[2:0] = 3'd5;
      tick();
      #2;
      rst = 1'b0; req = '0;
      #1;
      total++; if (q !== 8'h00 || busy !== 1'b0 || s_out !== 8'h00) begin bad++; $display("FAIL midrst_async got q=%h busy=%b s=%h exp 00/0/00", q, busy, s_out); end
      tick();
      rst = 1'b1;
      for (int c = 0; c < 4; c++) begin
         tick();
         total++; if (gnt !== 4'h0 || q !== 8'h00 || busy !== 1'b0) begin bad++; $display("FAIL midrst_after got gnt=%b q=%h busy=%b exp 0000/00/0", gnt, q, busy); end
      end
   endtask

   task automatic test_redundant();
      apply_reset();
      run_one(0, 1'b1, 3'd3);
      req = 4'b0001; req_op[0] = 1'b1; req_idx[2:0] = 3'd3;
      tick(); tick();
      total++; if (gnt !== 4'b0001 || err !== 1'b0) begin bad++; $display("FAIL redund_gnt got gnt=%b err=%b exp 0001/0", gnt, err); end
      total++; if (q !== 8'h08) begin bad++; $display("FAIL redund_q got=%h exp=08", q); end
      req = '0;
      tick();
   endtask

   initial begin
      test_reset();
      test_single_set();
      test_contention();
      test_fairness();
      test_out_of_range();
      test_reset_mid_apply();
      test_redundant();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
